// File: rtl/jk_drive_sequencer_if.sv
// Command channel into jk_drive_sequencer: one {j,k} op plus a drive length per transfer.
`timescale 1ns/1ps
interface jk_drive_sequencer_if #(
  parameter int LEN_W = 8
);
  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready are both high.
  // While cmd_valid is high and cmd_ready is low, the source holds cmd_op/cmd_len stable.
  // cmd_ready does not depend combinationally on cmd_valid.
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_len,
    output cmd_ready
  );
endinterface

// File: rtl/jk_drive_sequencer.sv
// Drives a JK flop's j/k/rstn for a commanded number of cycles, tracks the expected q with an
// internal JK model and flags any disagreement with the flop's q after each command.
`timescale 1ns/1ps
module jk_drive_sequencer #(
  parameter int LEN_W = 8,
  parameter int ERR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  jk_drive_sequencer_if.slave  cmd,
  output logic                 j,
  output logic                 k,
  output logic                 ff_rstn,
  input  logic                 ff_q,
  output logic                 busy,
  output logic                 done,
  output logic                 mismatch,
  output logic                 exp_q,
  output logic [ERR_W-1:0]     err_count,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t           state;
  logic             ready_q;
  logic [1:0]       op_q;
  logic [LEN_W-1:0] rem;

  assign cmd.cmd_ready = ready_q;
  assign busy          = (state == S_DRIVE) || (state == S_CHECK);
  assign dbg_state     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ready_q   <= 1'b0;
      op_q      <= 2'b00;
      rem       <= '0;
      j         <= 1'b0;
      k         <= 1'b0;
      ff_rstn   <= 1'b0;
      exp_q     <= 1'b0;
      err_count <= '0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      done     <= 1'b0;
      mismatch <= 1'b0;
      case (state)
        S_IDLE: begin
          j <= 1'b0;
          k <= 1'b0;
          // Release the flop first; ready rises one cycle later so the flop is out of reset.
          if (!ff_rstn) begin
            ff_rstn <= 1'b1;
          end else if (ready_q && cmd.cmd_valid) begin
            op_q    <= cmd.cmd_op;
            rem     <= (cmd.cmd_len == '0) ? LEN_W'(1) : cmd.cmd_len;
            {j, k}  <= cmd.cmd_op;
            ready_q <= 1'b0;
            state   <= S_DRIVE;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_DRIVE: begin
          case (op_q)
            2'b01:   exp_q <= 1'b0;
            2'b10:   exp_q <= 1'b1;
            2'b11:   exp_q <= ~exp_q;
            default: exp_q <= exp_q;
          endcase
          rem <= rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            j     <= 1'b0;
            k     <= 1'b0;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          done  <= 1'b1;
          state <= S_IDLE;
          if (ff_q != exp_q) begin
            mismatch <= 1'b1;
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
